fdivsqrt_r4_ctrl: RTL and testbench
===================================

// Module: fdivsqrt_r4_ctrl
// PURPOSE
//  Sequencing FSM for the radix-4 unified divide/sqrt iteration datapath. Accepts a start request,
//  initializes the residual registers, counts radix-4 steps, drives the j1/j2 first/second-iteration
//  flags consumed by the digit-selection table, and signals done until the result is consumed.
//  Sits between the execute-stage issue logic and the fdivsqrt iteration/postprocessing datapath.
// PARAMETERS
//  CNTW      7   width of step counter / CyclesE; supports up to 2^CNTW-1 radix-4 steps
// PORTS
//  clk           in   1     clock; all state updates on rising edge
//  reset         in   1     asynchronous, active-high; forces IDLE immediately
//  FDivStartE    in   1     start request (qualified internally by IDLE state)
//  SqrtE         in   1     operation is sqrt (1) or divide (0); sampled on accepted start
//  SpecialCaseE  in   1     result known without iteration (NaN/inf/zero/etc.); sampled on start
//  CyclesE       in   CNTW  number of radix-4 steps for this operation; sampled on start
//  StallM        in   1     downstream stall; holds DONE state
//  FlushE        in   1     cancel in-flight operation
//  IFDivStartE   out  1     1-cycle pulse: load initial residual/root registers
//  IterEnE       out  1     enable residual/quotient register update this cycle
//  FDivBusyE     out  1     unit occupied; stalls pipeline
//  FDivDoneE     out  1     result valid for postprocessing
//  j1, j2        out  1     sqrt 1st / 2nd iteration flags to digit selection
//  SqrtLatched   out  1     SqrtE captured at start, stable for whole operation
// BEHAVIOUR
//  Reset values: state=IDLE, step=0, all outputs 0, SqrtLatched=0.
//  States: IDLE, BUSY, DONE (2-bit encoding from package).
//  Accept = (state==IDLE) & FDivStartE & ~FlushE.
//  IDLE: Accept & SpecialCaseE -> DONE (no iterations, IFDivStartE=0).
//        Accept & ~SpecialCaseE -> BUSY; IFDivStartE=1 this cycle; step <= max(CyclesE,1);
//        iter index <= 0; SqrtLatched <= SqrtE. Otherwise stay IDLE.
//  BUSY: IterEnE=1 every cycle; step decrements; index increments (saturating at 2).
//        step==1 -> DONE next edge. Exactly max(CyclesE,1) BUSY cycles.
//  DONE: FDivDoneE=1; stay while StallM; ~StallM -> IDLE next edge.
//  FDivBusyE = (state==BUSY) | (Accept & ~SpecialCaseE); combinational, same cycle as start.
//  j1 = BUSY & SqrtLatched & index==0; j2 = BUSY & SqrtLatched & index==1; both 0 for divide.
//  CyclesE==1 sqrt: only j1 asserted; j2 never seen.
//  FlushE: any state -> IDLE next edge; outputs IterEnE/IFDivStartE suppressed in the flush cycle;
//        FlushE beats simultaneous FDivStartE; FlushE in DONE beats StallM.
//  FDivStartE while BUSY or DONE ignored (no restart, no reload).
//  Async reset mid-operation: immediate IDLE, counter cleared, no done pulse.
//  Latency (non-special, N=CyclesE>=1): start cycle 0, BUSY cycles 1..N, FDivDoneE first high N+1.
//  Special case: FDivDoneE high cycle 1.
// STRUCTURE
//  fdivsqrt_pkg: typedef enum logic [1:0] {IDLE, BUSY, DONE} divstate_t; CNTW default constant.
//  Sub-module fdivsqrt_stepcnt: CNTW-bit loadable down-counter, async reset, outputs Last (cnt==1).
//  Iteration index is a 2-bit saturating counter inside this module.
// TESTING
//  Divide, CyclesE=5 -> IFDivStartE cycle 0, IterEnE cycles 1-5, j1=j2=0, FDivDoneE cycle 6.
//  Sqrt, CyclesE=4 -> j1 cycle 1 only, j2 cycle 2 only, FDivDoneE cycle 5, SqrtLatched=1 throughout.
//  SpecialCaseE=1 at start -> FDivBusyE=0, no IterEnE, FDivDoneE cycle 1, IDLE cycle 2.
//  DONE with StallM high 3 cycles -> FDivDoneE held 4 cycles, IDLE after StallM drops; restart accepted.
//  FlushE in BUSY cycle 3 of CyclesE=8 -> IDLE next edge, no FDivDoneE; FlushE+Start same cycle -> ignored.
//  reset asserted mid-BUSY -> all outputs 0 asynchronously; CyclesE=0 -> exactly 1 BUSY cycle.

Source files
------------

// File: rtl/fdivsqrt_pkg.sv
// Shared types and constants for the radix-4 divide/sqrt sequencing logic.
package fdivsqrt_pkg;

  localparam int CNTW_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divstate_t;

endpackage

// File: rtl/fdivsqrt_stepcnt.sv
// Loadable down-counter tracking the remaining radix-4 steps; last flags the final step.
module fdivsqrt_stepcnt #(
  parameter int CNTW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic            last
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && (cnt != '0))  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CNTW'(1));

endmodule

// File: rtl/fdivsqrt_r4_ctrl.sv
// Sequencing FSM for the radix-4 unified divide/sqrt datapath: start, step counting,
// sqrt first/second iteration flags, and done hold until the result is consumed.
import fdivsqrt_pkg::*;

module fdivsqrt_r4_ctrl #(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FDivStartE,
  input  logic            SqrtE,
  input  logic            SpecialCaseE,
  input  logic [CNTW-1:0] CyclesE,
  input  logic            StallM,
  input  logic            FlushE,
  output logic            IFDivStartE,
  output logic            IterEnE,
  output logic            FDivBusyE,
  output logic            FDivDoneE,
  output logic            j1,
  output logic            j2,
  output logic            SqrtLatched,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  // Handshake: FDivStartE is a request taken only in IDLE and not during a flush;
  // FDivDoneE stays high until a cycle with StallM low lets the result be consumed.
  logic [1:0]      state, state_nxt;
  logic [1:0]      idx;
  logic            accept, start_iter, in_busy, last;
  logic [CNTW-1:0] load_val;

  assign in_busy    = (state == ST_BUSY);
  assign accept     = (state == ST_IDLE) & FDivStartE & ~FlushE;
  assign start_iter = accept & ~SpecialCaseE;
  // A zero step count still runs one iteration so the datapath always sees a load/iterate pair.
  assign load_val   = (CyclesE == '0) ? CNTW'(1) : CyclesE;

  fdivsqrt_stepcnt #(.CNTW(CNTW)) u_stepcnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (FlushE),
    .load     (start_iter),
    .load_val (load_val),
    .dec      (in_busy),
    .last     (last)
  );

  always_comb begin
    state_nxt = state;
    if (FlushE) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = SpecialCaseE ? ST_DONE : ST_BUSY;
        ST_BUSY: if (last)   state_nxt = ST_DONE;
        ST_DONE: if (!StallM) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      SqrtLatched <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_iter) begin
        idx         <= 2'd0;
        SqrtLatched <= SqrtE;
      end else if (in_busy && (idx != 2'd2)) begin
        idx <= idx + 2'd1;
      end
    end
  end

  assign IFDivStartE = start_iter;
  assign IterEnE     = in_busy & ~FlushE;
  assign FDivBusyE   = in_busy | start_iter;
  assign FDivDoneE   = (state == ST_DONE);
  assign j1          = in_busy & SqrtLatched & (idx == 2'd0);
  assign j2          = in_busy & SqrtLatched & (idx == 2'd1);
  assign state_dbg   = state;

endmodule

// File: tb/tb_fdivsqrt_r4_ctrl.sv
// Directed and randomized checks of the divide/sqrt sequencer against a latency-formula model.
module tb_fdivsqrt_r4_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       FDivStartE, SqrtE, SpecialCaseE, StallM, FlushE;
  logic [6:0] CyclesE;
  logic       IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, j1, j2, SqrtLatched;
  logic [1:0] state_dbg;

  int   checks   = 0;
  int   failures = 0;
  logic exp_lat  = 1'b0;

  fdivsqrt_r4_ctrl #(.CNTW(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .FDivStartE   (FDivStartE),
    .SqrtE        (SqrtE),
    .SpecialCaseE (SpecialCaseE),
    .CyclesE      (CyclesE),
    .StallM       (StallM),
    .FlushE       (FlushE),
    .IFDivStartE  (IFDivStartE),
    .IterEnE      (IterEnE),
    .FDivBusyE    (FDivBusyE),
    .FDivDoneE    (FDivDoneE),
    .j1           (j1),
    .j2           (j2),
    .SqrtLatched  (SqrtLatched),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Observed vector order: {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, j1, j2, SqrtLatched}
  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {IFDivStartE, IterEnE, FDivBusyE, FDivDoneE, j1, j2, SqrtLatched};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  // One operation. flush_k<0 means no flush; otherwise FlushE is raised in cycle flush_k.
  // Enters and leaves one time unit after a rising edge.
  task automatic run_op(input string name, input logic sq, input logic sp, input int cyc,
                        input int stall, input int flush_k);
    int   n, done_s, done_e, last_k;
    logic nsp, e_ifs, e_it, e_bsy, e_dn, e_j1, e_j2, e_lat;
    n      = (cyc == 0) ? 1 : cyc;
    done_s = sp ? 1 : n + 1;
    done_e = done_s + stall;
    last_k = (flush_k >= 0) ? flush_k : done_e;
    nsp    = ~sp;
    for (int k = 0; k <= last_k; k++) begin
      if (k == 0) begin
        FDivStartE = 1'b1; SqrtE = sq; SpecialCaseE = sp; CyclesE = 7'(cyc);
      end else begin
        FDivStartE   = 1'($urandom_range(0, 1));
        SqrtE        = 1'($urandom_range(0, 1));
        SpecialCaseE = 1'($urandom_range(0, 1));
        CyclesE      = 7'($urandom_range(0, 127));
      end
      FlushE = (k == flush_k);
      if (k >= done_s && k <= done_e) StallM = (k - done_s) < stall;
      else StallM = 1'($urandom_range(0, 1));
      if (flush_k == 0) begin
        {e_ifs, e_it, e_bsy, e_dn, e_j1, e_j2} = 6'b0;
        e_lat = exp_lat;
      end else begin
        e_ifs = nsp && (k == 0);
        e_it  = nsp && (k >= 1) && (k <= n) && (k != flush_k);
        e_bsy = nsp && (k <= n);
        e_dn  = (k >= done_s) && (k <= done_e);
        e_j1  = nsp && sq && (k == 1);
        e_j2  = nsp && sq && (k == 2) && (n >= 2);
        e_lat = (k == 0 || sp) ? exp_lat : sq;
      end
      @(negedge clk);
      chk($sformatf("%s_k%0d", name, k), {e_ifs, e_it, e_bsy, e_dn, e_j1, e_j2, e_lat});
      @(posedge clk); #1;
    end
    if (flush_k != 0 && !sp) exp_lat = sq;
    FDivStartE = 1'b0; FlushE = 1'b0; StallM = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_idle", name), {6'b0, exp_lat});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    FDivStartE = 1'b0; SqrtE = 1'b0; SpecialCaseE = 1'b0; CyclesE = '0;
    StallM = 1'b0; FlushE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 7'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 7'b0);
    @(posedge clk); #1;

    run_op("div_c5",      1'b0, 1'b0, 5, 0, -1);
    run_op("sqrt_c4",     1'b1, 1'b0, 4, 0, -1);
    run_op("special",     1'b0, 1'b1, 9, 0, -1);
    run_op("stall3",      1'b1, 1'b0, 3, 3, -1);
    run_op("restart",     1'b0, 1'b0, 2, 0, -1);
    run_op("flush_busy",  1'b0, 1'b0, 8, 0, 3);
    run_op("flush_start", 1'b1, 1'b0, 6, 0, 0);
    run_op("cyc0",        1'b1, 1'b0, 0, 0, -1);
    run_op("sqrt_c1",     1'b1, 1'b0, 1, 0, -1);
    run_op("flush_done",  1'b0, 1'b0, 2, 4, 5);
    run_op("div_c127",    1'b0, 1'b0, 127, 1, -1);

    // Asynchronous reset in the middle of an operation.
    FDivStartE = 1'b1; SqrtE = 1'b1; SpecialCaseE = 1'b0; CyclesE = 7'd8;
    @(posedge clk); #1;
    FDivStartE = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("async_reset_imm", 7'b0);
    exp_lat = 1'b0;
    @(negedge clk);
    chk("async_reset_held", 7'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_async_reset", 7'b0);
    @(posedge clk); #1;
    run_op("post_reset_op", 1'b1, 1'b0, 3, 0, -1);

    for (int i = 0; i < 40; i++) begin
      logic sq, sp;
      int   cyc, stall, fk, n, de;
      sq    = 1'($urandom_range(0, 1));
      sp    = ($urandom_range(0, 4) == 0);
      cyc   = $urandom_range(0, 20);
      stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      n     = (cyc == 0) ? 1 : cyc;
      de    = (sp ? 1 : n + 1) + stall;
      fk    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, de) : -1;
      run_op($sformatf("rnd%0d", i), sq, sp, cyc, stall, fk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
